tnn_neuron_seq: RTL
===================

// Module: tnn_neuron_seq
// PURPOSE
//  Sequential ternary-neuron accumulator, directly downstream of the 5-input popcount stage.
//  Each beat brings two 5-bit masks: inputs matching +1 weights and inputs matching -1 weights.
//  Both masks are popcounted; the block accumulates (pos - neg) over a multi-beat fan-in,
//  then thresholds the sum into one binary neuron output. valid/ready on both sides.
// PARAMETERS
//  MAX_BEATS  8   max beats per neuron evaluation (fan-in = 5*MAX_BEATS)
//  ACC_W      7   signed accumulator width, two's complement
//  THRESH     0   signed firing threshold; out_bit = (sum >= THRESH)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      beat valid
//  in_ready   out  1      block can accept a beat
//  in_pos     in   5      inputs matched with +1 weights
//  in_neg     in   5      inputs matched with -1 weights
//  in_last    in   1      final beat of this neuron evaluation
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts result
//  out_bit    out  1      neuron activation
//  out_sum    out  ACC_W  final signed sum
//  out_ovf    out  1      evaluation closed by MAX_BEATS, not by in_last
// BEHAVIOUR
//  Reset: acc=0, beat_cnt=0, state=ACC, out_valid=0, out_bit=0, out_sum=0, out_ovf=0; in_ready=1.
//  States: ACC (accepting beats), OUT (result held). in_ready = (state==ACC).
//  ACC: on in_valid&&in_ready: acc_n = acc + pc(in_pos) - pc(in_neg); beat_cnt++.
//  A bit set in both masks contributes 0 (+1 and -1 cancel); this is legal.
//  Close: accepted beat with in_last=1, or beat_cnt==MAX_BEATS-1 (out_ovf=1 unless in_last also set).
//  On close (same edge): out_sum<=acc_n, out_bit<=(acc_n>=THRESH), out_valid<=1, acc<=0,
//   beat_cnt<=0, state<=OUT. Latency: result visible 1 cycle after the accepting edge of the last beat.
//  OUT: outputs stable; in_ready=0. On out_valid&&out_ready -> out_valid<=0, state<=ACC;
//   a new beat can be accepted starting the following cycle (no same-cycle overlap).
//  in_valid low in ACC: acc holds; gaps between beats permitted.
//  rst_n asserted mid-evaluation: partial acc discarded, pending result dropped, reset values.
//  Arithmetic: pc() 3-bit unsigned (0..5), zero-extended to ACC_W before add/sub.
// CONFIGURATION
//  TNN_ACC_SAT_EN defined: acc_n clamps to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1] at each beat.
//  Not defined: acc_n wraps modulo 2^ACC_W (default params cannot overflow: |sum|<=40).
// STRUCTURE
//  tnn_pkg: TNN_PC_IN=5, TNN_PC_W=3, state enum {ST_ACC, ST_OUT}, signed acc typedef helper.
//  Sub-module tnn_popcount5 (input_a[4:0] -> 3-bit count), instantiated twice (pos, neg);
//  port-compatible with the approximate popcount05 variants so they swap in for error studies.
// TESTING
//  Reset: rst_n=0 -> out_valid=0, out_bit=0, out_sum=0, in_ready=1.
//  1 beat pos=5'b11111 neg=0 last=1 -> next cycle out_valid=1, out_sum=5, out_bit=1, out_ovf=0.
//  3 beats pos=5'b00011 neg=5'b11100, last on 3rd -> out_sum=-3, out_bit=0; overlap pos=neg=5'b11111 -> 0.
//  Backpressure: out_ready=0 for 4 cycles -> in_ready=0, outputs stable; out_ready=1 -> in_ready=1 next cycle.
//  8 beats pos=5'b00001 no last -> closes on 8th: out_sum=8, out_ovf=1; THRESH=9 -> out_bit=0.
//  ACC_W=4, 3 beats +5: SAT_EN -> out_sum=7; without -> out_sum=-1; rst_n pulse after beat 2 -> no out_valid.

Source files
------------

// File: rtl/tnn_pkg.sv
// Shared types and constants for the ternary neuron accumulator.
// Popcount geometry, FSM state encoding, default accumulator type.
package tnn_pkg;

  localparam int TNN_PC_IN = 5;
  localparam int TNN_PC_W  = 3;
  localparam int TNN_ACC_W = 7;

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } tnn_state_t;

  typedef logic signed [TNN_ACC_W-1:0] tnn_acc_t;

endpackage

// File: rtl/tnn_popcount5.sv
// Exact 5-input popcount; port-compatible with approximate variants.
// Counts set bits of input_a into a 3-bit unsigned result.
module tnn_popcount5
  import tnn_pkg::*;
(
  input  logic [TNN_PC_IN-1:0] input_a,
  output logic [TNN_PC_W-1:0]  count
);

  // sum the input bits
  always_comb begin
    count = '0;
    for (int i = 0; i < TNN_PC_IN; i++) begin
      count = count + TNN_PC_W'(input_a[i]);
    end
  end

endmodule

// File: rtl/tnn_neuron_seq.sv
// Sequential ternary neuron: accumulates pc(pos)-pc(neg), thresholds.
// TNN_ACC_SAT_EN: saturate the accumulator instead of wrapping.
module tnn_neuron_seq
  import tnn_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int ACC_W     = 7,
  parameter int THRESH    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [TNN_PC_IN-1:0]    in_pos,
  input  logic [TNN_PC_IN-1:0]    in_neg,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_bit,
  output logic signed [ACC_W-1:0] out_sum,
  output logic                    out_ovf
);

  localparam int CNT_W =
    (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  tnn_state_t              state, state_n;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [CNT_W-1:0]        beat_cnt;
  logic [TNN_PC_W-1:0]     pc_pos, pc_neg;
  logic                    accept, cnt_full;
  logic                    close_ev;
  logic signed [31:0]      sum_ext;

  tnn_popcount5 u_pc_pos (
    .input_a (in_pos),
    .count   (pc_pos)
  );

  tnn_popcount5 u_pc_neg (
    .input_a (in_neg),
    .count   (pc_neg)
  );

  assign in_ready = (state == ST_ACC);
  assign accept   = in_valid && in_ready;
  assign cnt_full = (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign close_ev = accept && (in_last || cnt_full);
  assign sum_ext  = 32'(acc_n);

`ifdef TNN_ACC_SAT_EN
  localparam logic signed [ACC_W+1:0] SAT_HI =
    {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] SAT_LO =
    {3'b111, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W+1:0] wide;

  // widened add, then clamp into the accumulator range
  always_comb begin
    wide = $signed({{2{acc[ACC_W-1]}}, acc})
         + $signed({{(ACC_W-1){1'b0}}, pc_pos})
         - $signed({{(ACC_W-1){1'b0}}, pc_neg});
    if (wide > SAT_HI) begin
      acc_n = SAT_HI[ACC_W-1:0];
    end else if (wide < SAT_LO) begin
      acc_n = SAT_LO[ACC_W-1:0];
    end else begin
      acc_n = wide[ACC_W-1:0];
    end
  end
`else
  assign acc_n = acc
    + $signed({{(ACC_W-TNN_PC_W){1'b0}}, pc_pos})
    - $signed({{(ACC_W-TNN_PC_W){1'b0}}, pc_neg});
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_n;
    end
  end

  // next-state: close a fan-in, or release the held result
  always_comb begin
    state_n = state;
    unique case (state)
      ST_ACC: if (close_ev) state_n = ST_OUT;
      ST_OUT: if (out_valid && out_ready) state_n = ST_ACC;
      default: state_n = ST_ACC;
    endcase
  end

  // accumulator, beat counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (close_ev) begin
      out_sum   <= acc_n;
      out_bit   <= (sum_ext >= THRESH);
      out_valid <= 1'b1;
      out_ovf   <= !in_last;
      acc       <= '0;
      beat_cnt  <= '0;
    end else if (accept) begin
      acc      <= acc_n;
      beat_cnt <= beat_cnt + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
